// File: rtl/prefetch_pkg.sv
// Shared widths and line-address helpers for
// the prefetch issue queue.
package prefetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int LINE_OFFSET = 6;
  localparam int LINE_W      = ADDR_W - LINE_OFFSET;

  typedef logic [LINE_W-1:0] line_addr_t;

  function automatic line_addr_t to_line(
    input logic [ADDR_W-1:0] addr
  );
    return addr[ADDR_W-1:LINE_OFFSET];
  endfunction

endpackage

// File: rtl/pf_sat_counter.sv
// Saturating event counter used for the
// prefetch queue drop/squash statistics.
module pf_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up on each event, sticking at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/prefetch_issue_queue.sv
// Circular queue between the prefetcher and the
// lower-level cache: dedups, squashes, issues FIFO.
module prefetch_issue_queue #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = prefetch_pkg::ADDR_W,
  parameter int LINE_OFFSET = prefetch_pkg::LINE_OFFSET,
  parameter int CNT_W       = 16,
  localparam int OCC_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] pf_address_i,
  input  logic              pf_valid_i,
  output logic              pf_accept_o,
  input  logic [ADDR_W-1:0] up_address_i,
  input  logic              up_valid_i,
  input  logic              up_miss_i,
  input  logic              lo_ready_i,
  output logic [ADDR_W-1:0] lo_prefetch_address_o,
  output logic              lo_prefetch_valid_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  dup_count_o,
  output logic [CNT_W-1:0]  full_drop_count_o,
  output logic [CNT_W-1:0]  squash_count_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LINE_W = ADDR_W - LINE_OFFSET;

  typedef logic [LINE_W-1:0] line_t;

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] live_q, live_d;
  line_t            line_q [DEPTH];
  line_t            line_d [DEPTH];

  line_t            pf_line, up_line, head_line;
  logic [DEPTH-1:0] slot_sq, slot_dup;
  logic             demand, occ_nz, full;
  logic             head_hit, valid, pop;
  logic             pf_sq, pf_dup, pf_full, push;
  logic             squash_hit;

  assign pf_line   = pf_address_i[ADDR_W-1:LINE_OFFSET];
  assign up_line   = up_address_i[ADDR_W-1:LINE_OFFSET];
  assign head_line = line_q[head_q];

  // Per-slot match against the demand miss and
  // against the incoming prefetch line.
  always_comb begin
    slot_sq  = '0;
    slot_dup = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_sq[i]  = demand & live_q[i]
                  & (line_q[i] == up_line);
      slot_dup[i] = live_q[i]
                  & (line_q[i] == pf_line);
    end
  end

  assign demand = up_valid_i & up_miss_i;
  assign occ_nz = |occ_q;
  assign full   = (occ_q == OCC_W'(DEPTH));

  // A demand to the head line hides it at once;
  // bubbles and squashed heads pop without issue.
  assign head_hit = demand & (head_line == up_line);
  assign valid    = occ_nz & live_q[head_q]
                  & ~head_hit;
  assign pop      = occ_nz & (lo_ready_i | ~valid);

  // Incoming request filter, in priority order.
  assign pf_sq   = pf_valid_i & demand
                 & (pf_line == up_line);
  assign pf_dup  = pf_valid_i & ~pf_sq & (|slot_dup);
  assign pf_full = pf_valid_i & ~pf_sq & ~pf_dup
                 & full & ~pop;
  assign push    = pf_valid_i & ~pf_sq & ~pf_dup
                 & ~pf_full;

  assign squash_hit = (|slot_sq) | pf_sq;

  // Next queue state: squash, then pop, then push
  // so a full-queue push reuses the popped slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    live_d = live_q & ~slot_sq;
    line_d = line_q;
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + IDX_W'(1);
    end
    if (push) begin
      line_d[tail_q] = pf_line;
      live_d[tail_q] = 1'b1;
      tail_d         = tail_q + IDX_W'(1);
    end
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // Queue storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      live_q <= live_d;
      line_q <= line_d;
    end
  end

  assign pf_accept_o           = push;
  assign lo_prefetch_valid_o   = valid;
  assign lo_prefetch_address_o =
    {head_line, {LINE_OFFSET{1'b0}}};
  assign occupancy_o           = occ_q;

  pf_sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (pf_dup),
    .count_o (dup_count_o)
  );

  pf_sat_counter #(.CNT_W(CNT_W)) u_full_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (pf_full),
    .count_o (full_drop_count_o)
  );

  pf_sat_counter #(.CNT_W(CNT_W)) u_sq_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (squash_hit),
    .count_o (squash_count_o)
  );

endmodule
